// File: rtl/fault_monitor.sv
// Two-rail error monitor: saturating per-channel counters, first-fault snapshot, persistence FSM with sticky alarm.
// 1-cycle registered latency; no backpressure, accepts a sample_en on every cycle.
module fault_monitor #(
  parameter int PERSIST = 3,
  parameter int CNT_W   = 8
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             clear,
  input  logic [2:0]       x,
  input  logic             xc,
  input  logic [1:0]       xe,
  input  logic [2:0]       y,
  input  logic             yc,
  input  logic [1:0]       ye,
  output logic [CNT_W-1:0] err_x_cnt,
  output logic [CNT_W-1:0] err_y_cnt,
  output logic [1:0]       fault_state,
  output logic             alarm,
  output logic             transient_pulse,
  output logic             snap_valid,
  output logic [2:0]       snap_x,
  output logic [2:0]       snap_y,
  output logic             snap_xc,
  output logic             snap_yc,
  output logic [1:0]       snap_src
);

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_SUSPECT   = 2'b01,
    ST_TRANSIENT = 2'b10,
    ST_PERMANENT = 2'b11
  } state_t;

  localparam logic [3:0]       PERSIST_L = 4'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic       x_bad;
  logic       y_bad;
  logic       bad;
  state_t     state_q;
  state_t     state_d;
  logic [3:0] run_q;
  logic [3:0] run_d;
  logic [3:0] run_inc;
  logic       pulse_d;

  assign x_bad   = ~(xe[1] ^ xe[0]);
  assign y_bad   = ~(ye[1] ^ ye[0]);
  assign bad     = x_bad | y_bad;
  assign run_inc = run_q + 4'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    if (sample_en) begin
      case (state_q)
        ST_OK: begin
          if (bad) begin
            state_d = ST_SUSPECT;
            run_d   = 4'd1;
          end
        end
        ST_SUSPECT: begin
          if (bad) begin
            run_d = run_inc;
            if (run_inc == PERSIST_L) state_d = ST_PERMANENT;
          end else begin
            state_d = ST_TRANSIENT;
            pulse_d = 1'b1;
          end
        end
        ST_TRANSIENT: begin
          if (bad) begin
            state_d = ST_SUSPECT;
            run_d   = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // alarm and pulse are registered from the next-state so they align with fault_state
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q         <= ST_OK;
      run_q           <= 4'd0;
      alarm           <= 1'b0;
      transient_pulse <= 1'b0;
    end else if (clear) begin
      state_q         <= ST_OK;
      run_q           <= 4'd0;
      alarm           <= 1'b0;
      transient_pulse <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_q           <= run_d;
      alarm           <= (state_d == ST_PERMANENT);
      transient_pulse <= pulse_d;
    end
  end

  assign fault_state = state_q;

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      err_x_cnt <= '0;
      err_y_cnt <= '0;
    end else if (clear) begin
      err_x_cnt <= '0;
      err_y_cnt <= '0;
    end else if (sample_en) begin
      if (x_bad && (err_x_cnt != CNT_MAX)) err_x_cnt <= err_x_cnt + 1'b1;
      if (y_bad && (err_y_cnt != CNT_MAX)) err_y_cnt <= err_y_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      snap_valid <= 1'b0;
      snap_x     <= 3'd0;
      snap_y     <= 3'd0;
      snap_xc    <= 1'b0;
      snap_yc    <= 1'b0;
      snap_src   <= 2'd0;
    end else if (clear) begin
      snap_valid <= 1'b0;
      snap_x     <= 3'd0;
      snap_y     <= 3'd0;
      snap_xc    <= 1'b0;
      snap_yc    <= 1'b0;
      snap_src   <= 2'd0;
    end else if (sample_en && bad && !snap_valid) begin
      snap_valid <= 1'b1;
      snap_x     <= x;
      snap_y     <= y;
      snap_xc    <= xc;
      snap_yc    <= yc;
      snap_src   <= {y_bad, x_bad};
    end
  end

endmodule

// File: tb/tb_fault_monitor.sv
// Directed bench for fault_monitor: abstract history model checked every cycle plus literal pins.
module tb_fault_monitor;

  localparam int PERSIST = 3;

  logic       clk_50 = 1'b0;
  logic       rst;
  logic       sample_en;
  logic       clear;
  logic [2:0] x;
  logic       xc;
  logic [1:0] xe;
  logic [2:0] y;
  logic       yc;
  logic [1:0] ye;

  logic [7:0] err_x_cnt, err_y_cnt;
  logic [1:0] fault_state, snap_src;
  logic       alarm, transient_pulse, snap_valid, snap_xc, snap_yc;
  logic [2:0] snap_x, snap_y;

  logic [1:0] n_err_x_cnt, n_err_y_cnt, n_fault_state, n_snap_src;
  logic       n_alarm, n_transient_pulse, n_snap_valid, n_snap_xc, n_snap_yc;
  logic [2:0] n_snap_x, n_snap_y;

  fault_monitor #(.PERSIST(PERSIST), .CNT_W(8)) u_dut (
    .clk_50(clk_50), .rst(rst), .sample_en(sample_en), .clear(clear),
    .x(x), .xc(xc), .xe(xe), .y(y), .yc(yc), .ye(ye),
    .err_x_cnt(err_x_cnt), .err_y_cnt(err_y_cnt), .fault_state(fault_state),
    .alarm(alarm), .transient_pulse(transient_pulse), .snap_valid(snap_valid),
    .snap_x(snap_x), .snap_y(snap_y), .snap_xc(snap_xc), .snap_yc(snap_yc),
    .snap_src(snap_src)
  );

  fault_monitor #(.PERSIST(PERSIST), .CNT_W(2)) u_dut_narrow (
    .clk_50(clk_50), .rst(rst), .sample_en(sample_en), .clear(clear),
    .x(x), .xc(xc), .xe(xe), .y(y), .yc(yc), .ye(ye),
    .err_x_cnt(n_err_x_cnt), .err_y_cnt(n_err_y_cnt), .fault_state(n_fault_state),
    .alarm(n_alarm), .transient_pulse(n_transient_pulse), .snap_valid(n_snap_valid),
    .snap_x(n_snap_x), .snap_y(n_snap_y), .snap_xc(n_snap_xc), .snap_yc(n_snap_yc),
    .snap_src(n_snap_src)
  );

  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;
  int pulses_seen = 0;

  // Model: fault history described as counts and a streak of consecutive bad samples
  int       m_cnt_x, m_cnt_y, m_streak;
  bit       m_perm, m_seen, m_pulse;
  bit       m_snap_valid;
  bit [2:0] m_snap_x, m_snap_y;
  bit       m_snap_xc, m_snap_yc;
  bit [1:0] m_snap_src;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_perm) return 2'd3;
    if (m_streak > 0) return 2'd1;
    if (m_seen) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_cnt_x = 0; m_cnt_y = 0; m_streak = 0;
    m_perm = 0; m_seen = 0; m_pulse = 0;
    m_snap_valid = 0; m_snap_x = 0; m_snap_y = 0;
    m_snap_xc = 0; m_snap_yc = 0; m_snap_src = 0;
  endtask

  task automatic model_sample(input bit sen, input bit clr, input logic [2:0] xv, input bit xcv,
                              input logic [1:0] xev, input logic [2:0] yv, input bit ycv,
                              input logic [1:0] yev);
    bit xb, yb;
    m_pulse = 0;
    if (clr) begin
      model_reset();
    end else if (sen) begin
      xb = (xev == 2'b00) || (xev == 2'b11);
      yb = (yev == 2'b00) || (yev == 2'b11);
      if (xb) m_cnt_x++;
      if (yb) m_cnt_y++;
      if ((xb || yb) && !m_snap_valid) begin
        m_snap_valid = 1; m_snap_x = xv; m_snap_y = yv;
        m_snap_xc = xcv; m_snap_yc = ycv; m_snap_src = {yb, xb};
      end
      if (!m_perm) begin
        if (xb || yb) begin
          m_streak++;
          m_seen = 1;
          if (m_streak >= PERSIST) m_perm = 1;
        end else begin
          if (m_streak > 0) m_pulse = 1;
          m_streak = 0;
        end
      end
    end
  endtask

  task automatic step(input bit sen, input bit clr, input logic [2:0] xv, input bit xcv,
                      input logic [1:0] xev, input logic [2:0] yv, input bit ycv,
                      input logic [1:0] yev);
    @(negedge clk_50);
    sample_en = sen; clear = clr;
    x = xv; xc = xcv; xe = xev; y = yv; yc = ycv; ye = yev;
    @(posedge clk_50);
    model_sample(sen, clr, xv, xcv, xev, yv, ycv, yev);
    #1;
    sample_en = 1'b0; clear = 1'b0;
  endtask

  task automatic clean_sample();
    step(1, 0, 3'b011, 1'b0, 2'b01, 3'b100, 1'b1, 2'b10);
  endtask

  task automatic idle();
    step(0, 0, 3'b111, 1'b1, 2'b00, 3'b111, 1'b1, 2'b11);
  endtask

  task automatic settle();
    @(negedge clk_50);
    #1;
  endtask

  always @(negedge clk_50) begin
    if (chk_en) begin
      check("err_x_cnt", err_x_cnt, sat(m_cnt_x, 8));
      check("err_y_cnt", err_y_cnt, sat(m_cnt_y, 8));
      check("fault_state", fault_state, model_state());
      check("alarm", alarm, m_perm);
      check("transient_pulse", transient_pulse, m_pulse);
      check("snap_valid", snap_valid, m_snap_valid);
      check("snap_x", snap_x, m_snap_x);
      check("snap_y", snap_y, m_snap_y);
      check("snap_xc", snap_xc, m_snap_xc);
      check("snap_yc", snap_yc, m_snap_yc);
      check("snap_src", snap_src, m_snap_src);
      check("narrow_err_x_cnt", n_err_x_cnt, sat(m_cnt_x, 2));
      check("narrow_err_y_cnt", n_err_y_cnt, sat(m_cnt_y, 2));
      check("narrow_fault_state", n_fault_state, model_state());
      if (transient_pulse) pulses_seen++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    rst = 1'b1; sample_en = 1'b0; clear = 1'b0;
    x = 0; xc = 0; xe = 0; y = 0; yc = 0; ye = 0;
    model_reset();
    #5;
    check("reset_fault_state", fault_state, 2'd0);
    check("reset_alarm", alarm, 1'b0);
    check("reset_err_x_cnt", err_x_cnt, 8'd0);
    check("reset_snap_valid", snap_valid, 1'b0);
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    chk_en = 1'b1;

    repeat (20) clean_sample();
    settle();
    check("clean_err_x_cnt", err_x_cnt, 8'd0);
    check("clean_err_y_cnt", err_y_cnt, 8'd0);
    check("clean_fault_state", fault_state, 2'd0);
    check("clean_snap_valid", snap_valid, 1'b0);

    p0 = pulses_seen;
    step(1, 0, 3'b101, 1'b1, 2'b11, 3'b010, 1'b0, 2'b10);
    settle();
    check("single_suspect", fault_state, 2'd1);
    repeat (3) clean_sample();
    settle();
    check("single_err_x_cnt", err_x_cnt, 8'd1);
    check("single_transient", fault_state, 2'd2);
    check("single_pulse_count", pulses_seen - p0, 1);
    check("single_snap", {snap_x, snap_xc, snap_y, snap_yc}, 8'b101_1_010_0);
    check("single_snap_src", snap_src, 2'b01);

    repeat (3) step(1, 0, 3'b000, 1'b0, 2'b01, 3'b110, 1'b1, 2'b00);
    settle();
    check("persist_state", fault_state, 2'd3);
    check("persist_alarm", alarm, 1'b1);
    check("persist_err_y_cnt", err_y_cnt, 8'd3);
    repeat (4) clean_sample();
    settle();
    check("sticky_alarm", alarm, 1'b1);
    check("snap_kept_x", snap_x, 3'b101);

    step(0, 1, 3'b000, 1'b0, 2'b01, 3'b000, 1'b0, 2'b10);
    step(1, 0, 3'b001, 1'b0, 2'b00, 3'b001, 1'b0, 2'b10);
    repeat (5) idle();
    step(1, 0, 3'b010, 1'b0, 2'b11, 3'b010, 1'b0, 2'b01);
    settle();
    check("gap_still_suspect", fault_state, 2'd1);
    repeat (5) idle();
    step(1, 0, 3'b011, 1'b0, 2'b00, 3'b011, 1'b0, 2'b01);
    settle();
    check("gap_permanent", fault_state, 2'd3);
    check("gap_alarm", alarm, 1'b1);

    step(0, 1, 3'b000, 1'b0, 2'b01, 3'b000, 1'b0, 2'b10);
    repeat (6) step(1, 0, 3'b110, 1'b1, 2'b00, 3'b001, 1'b0, 2'b11);
    settle();
    check("sat_narrow_x", n_err_x_cnt, 2'd3);
    check("sat_narrow_y", n_err_y_cnt, 2'd3);
    check("wide_x_six", err_x_cnt, 8'd6);
    check("snap_src_both", snap_src, 2'b11);

    step(1, 1, 3'b111, 1'b1, 2'b11, 3'b111, 1'b1, 2'b00);
    settle();
    check("clear_err_x_cnt", err_x_cnt, 8'd0);
    check("clear_snap_valid", snap_valid, 1'b0);
    check("clear_state", fault_state, 2'd0);
    check("clear_alarm", alarm, 1'b0);

    step(1, 0, 3'b100, 1'b0, 2'b11, 3'b100, 1'b0, 2'b10);
    settle();
    check("pre_rst_suspect", fault_state, 2'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_state", fault_state, 2'd0);
    check("rst_async_snap_valid", snap_valid, 1'b0);
    @(negedge clk_50);
    #2;
    rst = 1'b0;
    repeat (2) clean_sample();
    settle();
    check("post_rst_state", fault_state, 2'd0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fault_monitor.md
# fault_monitor

Sequential error monitor placed directly downstream of the self-checking `main` datapath. It samples the datapath outputs X/XC/Y/YC on a strobe and checks the two-rail error pairs XE/YE. It counts invalid codewords per channel, freezes a snapshot of the first faulty sample, and classifies the fault history as transient or permanent through a persistence FSM that drives a sticky alarm.

## Interface
Parameters:
- `PERSIST`, default 3: consecutive erroneous samples needed to declare a permanent fault; legal range 2..15.
- `CNT_W`, default 8: width of each saturating error counter.

Ports:
- `clk_50`  in  1  system clock, 50 MHz; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `sample_en`  in  1  qualifies the inputs below for one cycle.
- `clear`  in  1  synchronous clear of counters, snapshot, FSM and alarm.
- `x`  in  3  X word from `main`.
- `xc`  in  1  XC from `main`.
- `xe`  in  2  X two-rail error pair.
- `y`  in  3  Y word from `main`.
- `yc`  in  1  YC from `main`.
- `ye`  in  2  Y two-rail error pair.
- `err_x_cnt`  out  CNT_W  count of sampled invalid `xe` codes; saturating.
- `err_y_cnt`  out  CNT_W  count of sampled invalid `ye` codes; saturating.
- `fault_state`  out  2  00 OK, 01 SUSPECT, 10 TRANSIENT, 11 PERMANENT.
- `alarm`  out  1  high exactly while `fault_state` is PERMANENT.
- `transient_pulse`  out  1  one-cycle pulse on each entry into TRANSIENT.
- `snap_valid`  out  1  a snapshot is held.
- `snap_x`, `snap_y`  out  3 each  X and Y of the first faulty sample.
- `snap_xc`, `snap_yc`  out  1 each  XC and YC of the first faulty sample.
- `snap_src`  out  2  {y_bad, x_bad} of the first faulty sample.

## Operation
- Codeword validity: a pair is valid iff its bits differ (01 or 10). 00 and 11 are invalid. `x_bad = ~(xe[1]^xe[0])`, `y_bad = ~(ye[1]^ye[0])`, `bad = x_bad | y_bad`.
- Inputs are evaluated only in cycles with `sample_en=1`. With `sample_en=0`, all state holds, including the run counter.
- Counters: `err_x_cnt` increments by 1 on a sampled `x_bad`, and `err_y_cnt` on a sampled `y_bad`; both may increment in the same cycle. Each holds at 2^CNT_W-1 and never wraps.
- Snapshot: on the first sampled `bad` while `snap_valid=0`, capture x, xc, y, yc and {y_bad,x_bad}, then set `snap_valid`. Later faults never overwrite it until `clear` or `rst`.
- FSM, with an internal run counter `run` (4 bits), acting on sampled cycles only:
  - OK: `bad` → SUSPECT, run=1.
  - SUSPECT: `bad` → run+1. If run+1 == PERSIST, go to PERMANENT. A clean sample → TRANSIENT and pulse `transient_pulse`.
  - TRANSIENT: `bad` → SUSPECT, run=1. A clean sample → stay.
  - PERMANENT: absorbing; left only via `clear` or `rst`.
- `clear` has priority over `sample_en` in the same cycle. Everything returns to its reset value and that cycle's sample is dropped.

## Timing
- Reset values (async, immediate): counters 0, `fault_state`=00, `alarm`=0, `transient_pulse`=0, `snap_valid`=0, all `snap_*`=0, run=0.
- All outputs are registered. A sample at edge N is reflected in the outputs after edge N, with 1-cycle latency. No combinational path from input to output.
- `alarm` rises in the same cycle that `fault_state` becomes 11.
- `transient_pulse` is high for exactly one cycle per SUSPECT→TRANSIENT transition.
- `rst` asserted mid-sequence clears state immediately; run progress is lost. Deassertion is synchronised by the existing reset tree and needs no handling in this block.
- Back-to-back `sample_en` every cycle is supported with no bubbles.

## Test plan
- Reset, then 20 clean samples (xe=01, ye=10) → counters 0, `fault_state`=00, `alarm`=0, `snap_valid`=0.
- One sample with xe=11, x=101, xc=1, y=010, yc=0, then clean samples → `err_x_cnt`=1, SUSPECT then TRANSIENT, one `transient_pulse`, snapshot 101/1/010/0, `snap_src`=01.
- Three consecutive samples with ye=00 (PERSIST=3) → SUSPECT, SUSPECT, PERMANENT. `alarm`=1 after the third, `err_y_cnt`=3, `alarm` stays high through later clean samples.
- A faulty pair gapped by `sample_en=0` for 5 cycles, then a third faulty sample → PERMANENT; the gap does not reset run.
- CNT_W=2 with 6 samples having xe=00 and ye=11 → both counters saturate at 3.
- `clear` and a faulty `sample_en` in the same cycle → all outputs reset and the sample is ignored (`err_x_cnt`=0, `snap_valid`=0). `rst` pulsed while in SUSPECT → immediate `fault_state`=00.
